// File: rtl/ram8_access_ctrl.sv
// Request sequencer in front of an 8-word RAM8: turns valid/ready requests into timed
// load/address/in strobes, absorbs the registered read latency and offers a clear sweep.
module ram8_access_ctrl #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  clr_start,
    output logic                  clr_done,
    output logic                  busy,
    output logic                  ram_load,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_in,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RESP, CLR} state_t;

    state_t                  state_q;
    logic                    ram_load_q;
    logic [ADDR_WIDTH-1:0]   ram_address_q;
    logic [DATA_WIDTH-1:0]   ram_in_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    clr_done_q;

    // A pending clear request steals the IDLE slot, so the request channel is refused.
    assign req_ready   = (state_q == IDLE) && !clr_start;
    assign busy        = (state_q != IDLE);
    assign ram_load    = ram_load_q;
    assign ram_address = ram_address_q;
    assign ram_in      = ram_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign clr_done    = clr_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ram_load_q    <= 1'b0;
            ram_address_q <= '0;
            ram_in_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            clr_done_q    <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        ram_address_q <= '0;
                        ram_in_q      <= CLEAR_VALUE;
                        ram_load_q    <= 1'b1;
                        state_q       <= CLR;
                    end else if (req_valid) begin
                        ram_address_q <= req_addr;
                        if (req_we) begin
                            ram_in_q   <= req_data;
                            ram_load_q <= 1'b1;
                            state_q    <= WR;
                        end else begin
                            ram_load_q <= 1'b0;
                            state_q    <= RD1;
                        end
                    end
                end
                WR: begin
                    ram_load_q <= 1'b0;
                    state_q    <= IDLE;
                end
                // RAM8 captures the addressed word into ram_out at the end of RD1.
                RD1: state_q <= RD2;
                RD2: begin
                    rsp_data_q  <= ram_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                CLR: begin
                    if (&ram_address_q) begin
                        ram_load_q    <= 1'b0;
                        ram_address_q <= '0;
                        clr_done_q    <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        ram_address_q <= ram_address_q + 1'b1;
                    end
                end
                default: begin
                    ram_load_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_access_ctrl.sv
// Bench for ram8_access_ctrl: a registered-read RAM8 stand-in plus a word-array
// reference memory that predicts every read result and clear outcome.
module tb_ram8_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_addr;
   logic [15:0] req_data;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data;
   logic        clr_start, clr_done, busy;
   logic        ram_load;
   logic [2:0]  ram_address;
   logic [15:0] ram_in, ram_out;

   logic [15:0] mem [8] = '{default: 16'h0000};
   logic [15:0] refMem [8];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   ram8_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
      .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
      .ram_out(ram_out)
   );

   // RAM8 stand-in: write on load, read data registered one edge after the address.
   always @(posedge clk) begin
      if (ram_load) mem[ram_address] <= ram_in;
      ram_out <= mem[ram_address];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic doWrite(input logic [2:0] a, input logic [15:0] d, output bit ok);
      ok = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_data = d;
      for (int i = 0; i < 40; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      req_valid = 1'b0;
      if (ok) refMem[a] = d;
   endtask

   task automatic doRead(input logic [2:0] a, input int stall, output logic [15:0] d, output bit ok);
      bit accepted = 1'b0;
      ok = 1'b0;
      d = 'x;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      for (int i = 0; i < 40; i++) begin
         if (req_ready) begin
            accepted = 1'b1;
            tick();
            break;
         end
         tick();
      end
      req_valid = 1'b0;
      if (accepted) begin
         for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
      end
      if (ok) begin
         repeat (stall) tick();
         d = rsp_data;
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      checks++;
      if ({ram_load, ram_address, ram_in, rsp_valid, rsp_data, clr_done, busy} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: load=%0b addr=%0d in=%h rv=%0b rd=%h done=%0b busy=%0b, all must be 0",
                  ram_load, ram_address, ram_in, rsp_valid, rsp_data, clr_done, busy);
      end
      rst_n = 1'b1;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (3) tick();
      checks++;
      if (ram_load !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_pre_clr_load: got %0b want 1", ram_load);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ram_load !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_async_drop: load=%0b busy=%0b want 0/0", ram_load, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release: busy=%0b ready=%0b want 0/1", busy, req_ready);
      end
   endtask

   task automatic test_write_read();
      bit ok;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_data = 16'hBEEF;
      tick();
      req_valid = 1'b0;
      refMem[3] = 16'hBEEF;
      checks++;
      if (ram_load !== 1'b1 || ram_address !== 3'd3 || ram_in !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL wr_strobe: load=%0b addr=%0d in=%h want 1/3/beef", ram_load, ram_address, ram_in);
      end
      tick();
      checks++;
      if (ram_load !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_one_cycle: load=%0b busy=%0b want 0/0", ram_load, busy);
      end
      // Read accept edge counts as edge 1; the response shows after edge 3.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
      tick();
      req_valid = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_early_valid: got %0b want 0", rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL rd_latency_data: valid=%0b data=%h want 1/beef", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_handshake: valid=%0b busy=%0b want 0/0", rsp_valid, busy);
      end
      ok = 1'b1;
   endtask

   task automatic test_backpressure();
      bit ok;
      bit seen = 1'b0;
      doWrite(3'd5, 16'h1234, ok);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5;
      for (int i = 0; i < 40 && !req_ready; i++) tick();
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL bp_rsp_timeout: rsp_valid=%0b want 1", rsp_valid);
      end
      req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_data = 16'h7777;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cyc%0d: valid=%0b data=%h ready=%0b want 1/1234/0",
                     i, rsp_valid, rsp_data, req_ready);
         end
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL bp_release: valid=%0b ready=%0b data=%h want 0/1/1234", rsp_valid, req_ready, rsp_data);
      end
   endtask

   task automatic test_clear();
      bit ok;
      bit allOk = 1'b1;
      logic [15:0] d;
      for (int a = 0; a < 8; a++) begin
         doWrite(3'(a), 16'hFFFF, ok);
         allOk &= ok;
      end
      waitIdle(ok);
      allOk &= ok;
      checks++;
      if (!allOk) begin
         errors++;
         $display("[TB] FAIL clr_fill_timeout: ok=%0b want 1", allOk);
      end
      clr_start = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clr_req_ready: got %0b want 0", req_ready);
      end
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ram_load !== 1'b1 || ram_address !== 3'(i) || ram_in !== 16'h0000 || clr_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_sweep step%0d: load=%0b addr=%0d in=%h done=%0b want 1/%0d/0000/0",
                     i, ram_load, ram_address, ram_in, clr_done, i);
         end
         tick();
      end
      checks++;
      if (ram_load !== 1'b0 || clr_done !== 1'b1 || ram_address !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clr_end: load=%0b done=%0b addr=%0d busy=%0b want 0/1/0/0",
                  ram_load, clr_done, ram_address, busy);
      end
      tick();
      checks++;
      if (clr_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clr_done_pulse: got %0b want 0", clr_done);
      end
      for (int a = 0; a < 8; a++) refMem[a] = 16'h0000;
      for (int a = 0; a < 8; a++) begin
         doRead(3'(a), 0, d, ok);
         checks++;
         if (!ok || d !== refMem[a]) begin
            errors++;
            $display("[TB] FAIL clr_readback @%0d: got %h (ok=%0b) want %h", a, d, ok, refMem[a]);
         end
      end
   endtask

   task automatic test_clr_priority();
      bit ok;
      logic [15:0] d;
      doWrite(3'd2, 16'h5555, ok);
      waitIdle(ok);
      clr_start = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_data = 16'hAAAA;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL prio_ready: got %0b want 0", req_ready);
      end
      tick();
      clr_start = 1'b0;
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || ram_load !== 1'b1 || ram_address !== 3'd0 || ram_in !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL prio_clear_started: busy=%0b load=%0b addr=%0d in=%h want 1/1/0/0000",
                  busy, ram_load, ram_address, ram_in);
      end
      waitIdle(ok);
      for (int a = 0; a < 8; a++) refMem[a] = 16'h0000;
      doRead(3'd2, 1, d, ok);
      checks++;
      if (!ok || d !== refMem[2]) begin
         errors++;
         $display("[TB] FAIL prio_read @2: got %h (ok=%0b) want %h", d, ok, refMem[2]);
      end
   endtask

   task automatic test_back_to_back();
      int k = 0;
      int cyc = 0;
      int lastAcc = -1;
      bit ok;
      logic [15:0] d;
      logic [15:0] wd;
      waitIdle(ok);
      req_valid = 1'b1; req_we = 1'b1;
      wd = 16'($urandom);
      while (k < 8 && cyc < 60) begin
         req_addr = 3'(k);
         req_data = wd;
         if (req_ready) begin
            if (k > 0) begin
               checks++;
               if (cyc - lastAcc != 2) begin
                  errors++;
                  $display("[TB] FAIL b2b_spacing item%0d: got %0d cycles want 2", k, cyc - lastAcc);
               end
            end
            lastAcc = cyc;
            refMem[k] = wd;
            k++;
            wd = 16'($urandom);
         end
         tick();
         cyc++;
      end
      req_valid = 1'b0;
      checks++;
      if (k != 8) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d accepts want 8", k);
      end
      for (int a = 0; a < 8; a++) begin
         doRead(3'(a), 0, d, ok);
         checks++;
         if (!ok || d !== refMem[a]) begin
            errors++;
            $display("[TB] FAIL b2b_readback @%0d: got %h (ok=%0b) want %h", a, d, ok, refMem[a]);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [15:0] d;
      logic [2:0] a;
      for (int n = 0; n < 40; n++) begin
         a = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0: begin
               waitIdle(ok);
               clr_start = 1'b1;
               tick();
               clr_start = 1'b0;
               waitIdle(ok);
               for (int i = 0; i < 8; i++) refMem[i] = 16'h0000;
            end
            1, 2, 3, 4: doWrite(a, 16'($urandom), ok);
            default: begin
               doRead(a, $urandom_range(0, 3), d, ok);
               checks++;
               if (!ok || d !== refMem[a]) begin
                  errors++;
                  $display("[TB] FAIL rand_read op%0d @%0d: got %h (ok=%0b) want %h", n, a, d, ok, refMem[a]);
               end
            end
         endcase
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
      rsp_ready = 1'b0; clr_start = 1'b0;
      for (int i = 0; i < 8; i++) refMem[i] = 16'h0000;
      test_reset();
      test_write_read();
      test_backpressure();
      test_clear();
      test_clr_priority();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
